// File: rtl/tick_rate_pkg.sv
// tick_rate_pkg: shared elaboration helpers for the tick-rate timebase.
//   clog2      - ceiling log2 (returns 0 for v <= 1).
//   step_of    - accumulator increment for rate mode m (base**m).
//   clamp_mode - folds out-of-range mode requests onto the fastest mode.
package tick_rate_pkg;

    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic longint unsigned step_of(input int unsigned m,
                                                input int unsigned base);
        longint unsigned s;
        s = 1;
        for (int unsigned i = 0; i < m; i++) begin
            s = s * base;
        end
        return s;
    endfunction

    function automatic int unsigned clamp_mode(input int unsigned m,
                                               input int unsigned num_modes);
        return (m >= num_modes) ? num_modes - 1 : m;
    endfunction

endpackage

// File: rtl/tick_rate_gen_in_sync.sv
// in_sync: two-flop synchroniser for asynchronous board inputs, with an
// optional rising-edge strobe taken after synchronisation.
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset, clears every flop
//   d_i     - asynchronous input bits
//   q_o     - synchronised copy of d_i (2-cycle latency)
//   rise_o  - one-cycle strobe per synchronised 0->1 transition (EDGE=1),
//             constant zero otherwise
module in_sync #(
    parameter int unsigned W    = 1,
    parameter bit          EDGE = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = EDGE ? (sync_q & ~prev_q) : '0;

endmodule

// File: rtl/tick_rate_gen.sv
// tick_rate_gen: board timebase. A remainder-carry accumulator divides clk
// down to TICK_HZ (mode 0) or RATE_BASE**mode times faster, with pause and
// single-step, a square-wave companion, a modulo tick counter and a
// free-running display-scan strobe.
//   clk       - board clock
//   rst_n     - asynchronous active-low reset
//   en        - run enable (async level)
//   mode      - requested rate mode (async), clamped to NUM_MODES-1
//   step_req  - single-step request (async level), honoured while paused
//   tick      - one-cycle tick strobe
//   sq        - toggles on every tick
//   scan_tick - one-cycle strobe every 2**SCAN_LOG2 cycles
//   tick_cnt  - tick count modulo CNT_MOD
//   cnt_wrap  - strobe with the tick that wraps tick_cnt to 0
//   mode_q    - rate mode currently applied
module tick_rate_gen
    import tick_rate_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned NUM_MODES = 4,
    parameter int unsigned RATE_BASE = 5,
    parameter int unsigned SCAN_LOG2 = 16,
    parameter int unsigned CNT_MOD   = 60,
    localparam int unsigned MODE_W   = (clog2(NUM_MODES) < 1) ? 1 : clog2(NUM_MODES),
    localparam int unsigned CNT_W    = (clog2(CNT_MOD) < 1) ? 1 : clog2(CNT_MOD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic              step_req,
    output logic              tick,
    output logic              sq,
    output logic              scan_tick,
    output logic [CNT_W-1:0]  tick_cnt,
    output logic              cnt_wrap,
    output logic [MODE_W-1:0] mode_q
);

    localparam int unsigned TERMINAL = CLK_HZ / TICK_HZ;
    // Headroom for acc (< TERMINAL) plus one step (<= TERMINAL).
    localparam int unsigned ACC_W    = clog2(2 * 64'(TERMINAL));
    localparam logic [ACC_W-1:0] TERM_V   = ACC_W'(TERMINAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MOD - 1);

    if (step_of(NUM_MODES - 1, RATE_BASE) > 64'(TERMINAL) || TERMINAL < 2) begin : g_cfg_err
        $error("tick_rate_gen: RATE_BASE**(NUM_MODES-1) must not exceed CLK_HZ/TICK_HZ, which must be >= 2");
    end

    logic [ACC_W-1:0] step_tab [NUM_MODES];
    for (genvar g = 0; g < NUM_MODES; g++) begin : g_step
        assign step_tab[g] = ACC_W'(step_of(g, RATE_BASE));
    end

    // Input synchronisation
    logic              en_s;
    logic [MODE_W-1:0] mode_s;
    logic              step_s;
    logic              step_rise;
    logic              unused_en_rise;
    logic [MODE_W-1:0] unused_mode_rise;
    logic              unused_sync;

    in_sync #(.W(1), .EDGE(1'b0)) u_sync_en (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (en),
        .q_o    (en_s),
        .rise_o (unused_en_rise)
    );

    in_sync #(.W(MODE_W), .EDGE(1'b0)) u_sync_mode (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (mode),
        .q_o    (mode_s),
        .rise_o (unused_mode_rise)
    );

    in_sync #(.W(1), .EDGE(1'b1)) u_sync_step (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (step_req),
        .q_o    (step_s),
        .rise_o (step_rise)
    );

    assign unused_sync = ^{unused_en_rise, unused_mode_rise, step_s};

    // State
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     sum;
    logic                 tick_q, tick_d;
    logic                 sq_q, sq_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;
    logic [MODE_W-1:0]    mode_reg_q, mode_reg_d;
    logic [SCAN_LOG2-1:0] scan_q, scan_d;
    logic                 scan_tick_q, scan_tick_d;

    always_comb begin
        acc_d  = acc_q;
        tick_d = 1'b0;
        sum    = acc_q + step_tab[mode_reg_q];

        // Paused: acc frozen, and a threshold crossing in the same cycle the
        // synced enable drops is simply not evaluated (pause wins).
        if (en_s) begin
            if (sum >= TERM_V) begin
                acc_d  = sum - TERM_V;
                tick_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end else begin
            tick_d = step_rise;
        end

        // Tick side effects are registered alongside tick itself.
        sq_d   = sq_q ^ tick_d;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (tick_d) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Takes effect on the next accumulate; acc is left untouched.
        mode_reg_d = MODE_W'(clamp_mode(32'(mode_s), NUM_MODES));

        scan_d      = scan_q + SCAN_LOG2'(1);
        scan_tick_d = (scan_d == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            tick_q      <= 1'b0;
            sq_q        <= 1'b0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            mode_reg_q  <= '0;
            scan_q      <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            mode_reg_q  <= mode_reg_d;
            scan_q      <= scan_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign tick      = tick_q;
    assign sq        = sq_q;
    assign scan_tick = scan_tick_q;
    assign tick_cnt  = cnt_q;
    assign cnt_wrap  = wrap_q;
    assign mode_q    = mode_reg_q;

endmodule

// File: tb/tb_tick_rate_gen.sv
// Self-checking bench for tick_rate_gen with a 200-cycle terminal count.
module tb_tick_rate_gen;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned TICK_HZ   = 5;
    localparam int unsigned NUM_MODES = 4;
    localparam int unsigned RATE_BASE = 5;
    localparam int unsigned SCAN_LOG2 = 4;
    localparam int unsigned CNT_MOD   = 3;
    localparam int unsigned TERM      = CLK_HZ / TICK_HZ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       step_req;
    logic       tick;
    logic       sq;
    logic       scan_tick;
    logic [1:0] tick_cnt;
    logic       cnt_wrap;
    logic [1:0] mode_q;

    tick_rate_gen #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .NUM_MODES (NUM_MODES),
        .RATE_BASE (RATE_BASE),
        .SCAN_LOG2 (SCAN_LOG2),
        .CNT_MOD   (CNT_MOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .step_req  (step_req),
        .tick      (tick),
        .sq        (sq),
        .scan_tick (scan_tick),
        .tick_cnt  (tick_cnt),
        .cnt_wrap  (cnt_wrap),
        .mode_q    (mode_q)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Scoreboard of expected tick cycles, plus a tick-count model.
    int unsigned exp_q[$];
    bit          sb_on      = 1'b0;
    int unsigned model_t    = 0;
    int unsigned wraps_seen = 0;
    int unsigned last_scan  = 0;
    bit          scan_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_t    = 0;
                scan_valid = 1'b0;
            end else begin
                if (tick === 1'b1) begin
                    model_t++;
                    chk("tick_cnt", 64'(tick_cnt), 64'(model_t % CNT_MOD));
                    chk("sq", 64'(sq), 64'(model_t % 2));
                    chk("cnt_wrap", 64'(cnt_wrap), 64'((model_t % CNT_MOD) == 0));
                    if (cnt_wrap === 1'b1) wraps_seen++;
                    if (sb_on) begin
                        chk("sb_tick_expected", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) chk("tick_cycle", 64'(cyc), 64'(exp_q.pop_front()));
                    end
                end else begin
                    chk("wrap_without_tick", 64'(cnt_wrap), 64'd0);
                end
                if (scan_tick === 1'b1) begin
                    if (scan_valid) chk("scan_period", 64'(cyc - last_scan), 64'd16);
                    scan_valid = 1'b1;
                    last_scan  = cyc;
                end
            end
        end
    end

    task automatic wait_tick(input string name, input int unsigned budget,
                             output int unsigned at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_mode(input logic [1:0] m, input int unsigned budget,
                             output int unsigned at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mode_q === m) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("mode_q_follow");
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  exp_mode;
        int unsigned period;
        int unsigned n;
    } vec_t;

    initial begin
        vec_t        vecs [3];
        int unsigned c, c0, r, t_ref, t1, t2, tchg, lat;
        int unsigned ntk, last, gap, maxgap, wr0, mt0;
        bit          got;

        vecs[0] = '{mode: 2'd1, exp_mode: 2'd1, period: 40,  n: 4};
        vecs[1] = '{mode: 2'd2, exp_mode: 2'd2, period: 8,   n: 6};
        vecs[2] = '{mode: 2'd0, exp_mode: 2'd0, period: 200, n: 2};

        rst_n = 1'b0; en = 1'b0; mode = 2'd0; step_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_sq", 64'(sq), 64'd0);
        chk("rst_scan", 64'(scan_tick), 64'd0);
        chk("rst_cnt", 64'(tick_cnt), 64'd0);
        chk("rst_wrap", 64'(cnt_wrap), 64'd0);
        chk("rst_mode", 64'(mode_q), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 0: first tick 200 cycles after synced en, then every 200.
        en = 1'b1; c0 = cyc; sb_on = 1'b1;
        for (int unsigned k = 0; k < 3; k++) exp_q.push_back(c0 + 202 + k * TERM);
        repeat (605) @(negedge clk);
        chk("sbA_drained", 64'(exp_q.size()), 64'd0);
        sb_on = 1'b0; exp_q.delete();

        // Mode table: no phase reset on switch, then exact periods.
        for (int unsigned i = 0; i < 3; i++) begin
            mode = vecs[i].mode; c = cyc;
            wait_mode(vecs[i].exp_mode, 6, tchg, got);
            if (got) begin
                lat = tchg - c;
                chk("mode_latency", 64'(lat >= 2 && lat <= 3), 64'd1);
            end
            wait_tick("first_tick", vecs[i].period + 5, t1, got);
            if (got) chk("first_interval_le_period", 64'((t1 - tchg) <= vecs[i].period), 64'd1);
            for (int unsigned k = 0; k < vecs[i].n; k++) begin
                wait_tick("period_tick", vecs[i].period + 5, t2, got);
                if (got) chk("period", 64'(t2 - t1), 64'(vecs[i].period));
                t1 = t2;
            end
        end

        // Mode 3 (step 125): exactly 625 ticks in 1000 cycles.
        mode = 2'd3;
        wait_mode(2'd3, 6, tchg, got);
        ntk = 0; maxgap = 0; last = cyc;
        for (int unsigned k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                ntk++;
                gap = cyc - last;
                if (gap > maxgap) maxgap = gap;
                last = cyc;
            end
        end
        chk("m3_ticks_1000", 64'(ntk), 64'd625);
        chk("m3_max_gap", 64'(maxgap), 64'd2);

        // Pause mid-count, three single steps, resume with acc intact.
        mode = 2'd0;
        wait_mode(2'd0, 6, tchg, got);
        wait_tick("pause_ref_tick", TERM + 10, t_ref, got);
        repeat (50) @(negedge clk);
        en = 1'b0; c = cyc;
        wr0 = wraps_seen; mt0 = model_t;
        repeat (5) @(negedge clk);
        sb_on = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            step_req = 1'b1;
            exp_q.push_back(cyc + 3);
            repeat (5) @(negedge clk);
            step_req = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("pause_ticks", 64'(model_t - mt0), 64'd3);
        chk("pause_wraps", 64'(wraps_seen - wr0), 64'd1);
        chk("pause_steps_drained", 64'(exp_q.size()), 64'd0);
        r = cyc; en = 1'b1;
        exp_q.push_back(t_ref + TERM + (r - c));
        repeat (155) @(negedge clk);
        chk("resume_drained", 64'(exp_q.size()), 64'd0);
        sb_on = 1'b0; exp_q.delete();

        // Async reset mid-count while tick_cnt and mode_q are non-zero.
        mode = 2'd1;
        wait_mode(2'd1, 6, tchg, got);
        for (int unsigned k = 0; k < 4; k++) begin
            wait_tick("pre_reset_tick", 50, t1, got);
            if (!got || (model_t % CNT_MOD) == 1) break;
        end
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", 64'(tick), 64'd0);
        chk("arst_sq", 64'(sq), 64'd0);
        chk("arst_scan", 64'(scan_tick), 64'd0);
        chk("arst_cnt", 64'(tick_cnt), 64'd0);
        chk("arst_wrap", 64'(cnt_wrap), 64'd0);
        chk("arst_mode", 64'(mode_q), 64'd0);
        mode = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; c = cyc; sb_on = 1'b1;
        exp_q.push_back(c + 202);
        repeat (210) @(negedge clk);
        chk("post_reset_drained", 64'(exp_q.size()), 64'd0);
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
